hazard_controller: RTL

//  Pipeline sequencer for the 5-stage RV32 core. Drives the EX-stage forwarding muxes
//  (sources: MEM result, WB result, register file). Detects load-use hazards and inserts
//  one bubble. Holds the pipe for the multi-cycle MUL/DIV unit (MDU) via start/done

---
 rtl/hazard_controller_pkg.sv | 18 +
 rtl/hazard_controller_if.sv | 64 ++++++
 rtl/hazard_controller_fwd_select.sv | 28 ++
 rtl/hazard_controller.sv | 124 ++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types for the RV32 hazard controller:
// forwarding selects, FSM states and the x0 register index.
package rapid_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_MEM  = 2'd1,
      FWD_WB   = 2'd2
   } fwd_sel_t;

   typedef enum logic {
      HZ_RUN,
      HZ_MDU_WAIT
   } hz_state_t;

   localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller bundle.
// master: pipeline side (drives i_*), slave: controller (drives o_*).
import rapid_pkg::*;

interface hazard_controller_if #(
   parameter int CNT_W = 32
);
   logic             i_id_valid;
   logic [4:0]       i_id_rs1;
   logic [4:0]       i_id_rs2;
   logic [4:0]       i_ex_rs1;
   logic [4:0]       i_ex_rs2;
   logic [4:0]       i_ex_rd;
   logic             i_ex_reg_write;
   logic             i_ex_mem_read;
   logic             i_ex_mdu_valid;
   logic             i_ex_branch_taken;
   logic [4:0]       i_mem_rd;
   logic [4:0]       i_wb_rd;
   logic             i_mem_reg_write;
   logic             i_wb_reg_write;
   logic             i_mdu_done;
   fwd_sel_t         o_fwd_rs1_sel;
   fwd_sel_t         o_fwd_rs2_sel;
   logic             o_stall_if;
   logic             o_stall_id;
   logic             o_stall_ex;
   logic             o_flush_id;
   logic             o_flush_ex;
   logic             o_mdu_start;
   logic             o_mdu_timeout;
   logic [CNT_W-1:0] o_stall_cnt;
   logic [CNT_W-1:0] o_flush_cnt;

   modport master (
      output i_id_valid, i_id_rs1, i_id_rs2,
      output i_ex_rs1, i_ex_rs2, i_ex_rd,
      output i_ex_reg_write, i_ex_mem_read,
      output i_ex_mdu_valid, i_ex_branch_taken,
      output i_mem_rd, i_wb_rd,
      output i_mem_reg_write, i_wb_reg_write,
      output i_mdu_done,
      input  o_fwd_rs1_sel, o_fwd_rs2_sel,
      input  o_stall_if, o_stall_id, o_stall_ex,
      input  o_flush_id, o_flush_ex,
      input  o_mdu_start, o_mdu_timeout,
      input  o_stall_cnt, o_flush_cnt
   );

   modport slave (
      input  i_id_valid, i_id_rs1, i_id_rs2,
      input  i_ex_rs1, i_ex_rs2, i_ex_rd,
      input  i_ex_reg_write, i_ex_mem_read,
      input  i_ex_mdu_valid, i_ex_branch_taken,
      input  i_mem_rd, i_wb_rd,
      input  i_mem_reg_write, i_wb_reg_write,
      input  i_mdu_done,
      output o_fwd_rs1_sel, o_fwd_rs2_sel,
      output o_stall_if, o_stall_id, o_stall_ex,
      output o_flush_id, o_flush_ex,
      output o_mdu_start, o_mdu_timeout,
      output o_stall_cnt, o_flush_cnt
   );
endinterface

// File: rtl/hazard_controller_fwd_select.sv
// Forwarding source select for one EX operand.
// Ports: rs, mem_rd/mem_wr, wb_rd/wb_wr in; sel out (MEM beats WB).
import rapid_pkg::*;

module fwd_select (
   input  logic [4:0] rs,
   input  logic [4:0] mem_rd,
   input  logic       mem_wr,
   input  logic [4:0] wb_rd,
   input  logic       wb_wr,
   output fwd_sel_t   sel
);
   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_wr && (mem_rd != REG_X0) && (mem_rd == rs);
   assign wb_hit  = wb_wr && (wb_rd != REG_X0) && (wb_rd == rs);

   always_comb begin
      sel = FWD_NONE;
      if (rs == REG_X0)
         sel = FWD_NONE;
      else if (mem_hit)
         sel = FWD_MEM;
      else if (wb_hit)
         sel = FWD_WB;
   end
endmodule

// File: rtl/hazard_controller.sv
// Hazard controller: forwarding, load-use bubble, MDU hold w/ timeout,
// branch flush, saturating stall/flush counters. Ports: i_clk, i_rst_n, hz.
import rapid_pkg::*;

module hazard_controller #(
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   hazard_controller_if.slave  hz
);
   localparam int TW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(MDU_TIMEOUT - 1);

   hz_state_t        state, state_nxt;
   logic [TW-1:0]    timer;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic             to_flag;
   logic             to_hit;
   logic             load_use;
   logic             s_if, s_id, s_ex, f_id, f_ex, start;
   fwd_sel_t         sel1, sel2;

   fwd_select u_fwd_rs1 (
      .rs     (hz.i_ex_rs1),
      .mem_rd (hz.i_mem_rd),
      .mem_wr (hz.i_mem_reg_write),
      .wb_rd  (hz.i_wb_rd),
      .wb_wr  (hz.i_wb_reg_write),
      .sel    (sel1)
   );

   fwd_select u_fwd_rs2 (
      .rs     (hz.i_ex_rs2),
      .mem_rd (hz.i_mem_rd),
      .mem_wr (hz.i_mem_reg_write),
      .wb_rd  (hz.i_wb_rd),
      .wb_wr  (hz.i_wb_reg_write),
      .sel    (sel2)
   );

   assign load_use = hz.i_ex_mem_read && hz.i_ex_reg_write
                  && (hz.i_ex_rd != REG_X0) && hz.i_id_valid
                  && ((hz.i_ex_rd == hz.i_id_rs1)
                   || (hz.i_ex_rd == hz.i_id_rs2));

   always_comb begin
      state_nxt = state;
      s_if      = 1'b0;
      s_id      = 1'b0;
      s_ex      = 1'b0;
      f_id      = 1'b0;
      f_ex      = 1'b0;
      start     = 1'b0;
      to_hit    = 1'b0;
      unique case (state)
         HZ_RUN: begin
            if (hz.i_ex_branch_taken) begin
               f_id = 1'b1;
               f_ex = 1'b1;
            end else if (hz.i_ex_mdu_valid) begin
               start     = 1'b1;
               s_if      = 1'b1;
               s_id      = 1'b1;
               s_ex      = 1'b1;
               state_nxt = HZ_MDU_WAIT;
            end else if (load_use) begin
               s_if = 1'b1;
               s_id = 1'b1;
               f_ex = 1'b1;
            end
         end
         HZ_MDU_WAIT: begin
            // done is checked first so it masks a same-cycle timeout
            if (hz.i_mdu_done) begin
               state_nxt = HZ_RUN;
            end else if (timer == TO_LAST) begin
               to_hit    = 1'b1;
               state_nxt = HZ_RUN;
            end else begin
               s_if = 1'b1;
               s_id = 1'b1;
               s_ex = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state     <= HZ_RUN;
         timer     <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
         to_flag   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start)
            timer <= '0;
         else if (state == HZ_MDU_WAIT)
            timer <= timer + 1'b1;
         if (s_id && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (f_id && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
         if (to_hit)
            to_flag <= 1'b1;
      end
   end

   // control outputs are forced quiet while reset is held
   assign hz.o_stall_if    = i_rst_n & s_if;
   assign hz.o_stall_id    = i_rst_n & s_id;
   assign hz.o_stall_ex    = i_rst_n & s_ex;
   assign hz.o_flush_id    = i_rst_n & f_id;
   assign hz.o_flush_ex    = i_rst_n & f_ex;
   assign hz.o_mdu_start   = i_rst_n & start;
   assign hz.o_fwd_rs1_sel = i_rst_n ? sel1 : FWD_NONE;
   assign hz.o_fwd_rs2_sel = i_rst_n ? sel2 : FWD_NONE;
   assign hz.o_mdu_timeout = to_flag;
   assign hz.o_stall_cnt   = stall_cnt;
   assign hz.o_flush_cnt   = flush_cnt;
endmodule
